// File: rtl/maq_bcd_cont.sv
// Two-digit BCD modulo counter (MINIMO..MAXIMO) with synchronous preset and
// single-cycle carry/borrow pulses; one instance per clock time field.
module maq_bcd_cont #(
  parameter int MINIMO = 0,
  parameter int MAXIMO = 23
) (
  input  logic       maqc_clock,
  input  logic       maqc_reset,
  input  logic       maqc_enable,
  input  logic       maqc_incremento,
  input  logic       maqc_decremento,
  input  logic       maqc_carga,
  input  logic [3:0] maqc_carga_msd,
  input  logic [3:0] maqc_carga_lsd,
  output logic [3:0] maqc_msd,
  output logic [3:0] maqc_lsd,
  output logic       maqc_carry,
  output logic       maqc_borrow,
  output logic       maqc_erro
);

  if (MINIMO < 0 || MINIMO >= MAXIMO || MAXIMO > 99) begin : g_bad_bounds
    $error("maq_bcd_cont: illegal bounds MINIMO=%0d MAXIMO=%0d", MINIMO, MAXIMO);
  end

  localparam logic [3:0] MIN_MSD = 4'(MINIMO / 10);
  localparam logic [3:0] MIN_LSD = 4'(MINIMO % 10);
  localparam logic [3:0] MAX_MSD = 4'(MAXIMO / 10);
  localparam logic [3:0] MAX_LSD = 4'(MAXIMO % 10);

  int         cur_val;
  int         load_val;
  logic       load_ok;
  logic       step_up;
  logic       step_down;
  logic [3:0] msd_next;
  logic [3:0] lsd_next;
  logic       carry_next;
  logic       borrow_next;
  logic       erro_next;

  // Bound checks use the full two-digit value so 19->20 and 23->00 behave.
  always_comb begin
    cur_val     = 10 * int'(maqc_msd) + int'(maqc_lsd);
    load_val    = 10 * int'(maqc_carga_msd) + int'(maqc_carga_lsd);
    load_ok     = (maqc_carga_msd <= 4'd9) && (maqc_carga_lsd <= 4'd9) &&
                  (load_val >= MINIMO) && (load_val <= MAXIMO);
    step_up     = maqc_enable && maqc_incremento && !maqc_decremento;
    step_down   = maqc_enable && maqc_decremento && !maqc_incremento;
    msd_next    = maqc_msd;
    lsd_next    = maqc_lsd;
    carry_next  = 1'b0;
    borrow_next = 1'b0;
    erro_next   = 1'b0;

    if (maqc_carga) begin
      if (load_ok) begin
        msd_next = maqc_carga_msd;
        lsd_next = maqc_carga_lsd;
      end else begin
        erro_next = 1'b1;
      end
    end else if (step_up) begin
      if (cur_val == MAXIMO) begin
        msd_next   = MIN_MSD;
        lsd_next   = MIN_LSD;
        carry_next = 1'b1;
      end else if (maqc_lsd == 4'd9) begin
        lsd_next = 4'd0;
        msd_next = maqc_msd + 4'd1;
      end else begin
        lsd_next = maqc_lsd + 4'd1;
      end
    end else if (step_down) begin
      if (cur_val == MINIMO) begin
        msd_next    = MAX_MSD;
        lsd_next    = MAX_LSD;
        borrow_next = 1'b1;
      end else if (maqc_lsd == 4'd0) begin
        lsd_next = 4'd9;
        msd_next = maqc_msd - 4'd1;
      end else begin
        lsd_next = maqc_lsd - 4'd1;
      end
    end
  end

  always_ff @(posedge maqc_clock or negedge maqc_reset) begin
    if (!maqc_reset) begin
      maqc_msd    <= MIN_MSD;
      maqc_lsd    <= MIN_LSD;
      maqc_carry  <= 1'b0;
      maqc_borrow <= 1'b0;
      maqc_erro   <= 1'b0;
    end else begin
      maqc_msd    <= msd_next;
      maqc_lsd    <= lsd_next;
      maqc_carry  <= carry_next;
      maqc_borrow <= borrow_next;
      maqc_erro   <= erro_next;
    end
  end

endmodule

// File: tb/tb_maq_bcd_cont.sv
// Bench for maq_bcd_cont: three bound sets driven in parallel against an
// integer reference model, plus a seconds->minutes->hours cascade.
module tb_maq_bcd_cont;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0, inc = 1'b0, dec = 1'b0, carga = 1'b0;
  logic [3:0] cmsd = 4'd0, clsd = 4'd0;
  logic [3:0] o_msd [3];
  logic [3:0] o_lsd [3];
  logic       o_carry [3];
  logic       o_borrow [3];
  logic       o_erro [3];

  int checks = 0;
  int errors = 0;

  int   mn [3] = '{0, 1, 0};
  int   mx [3] = '{23, 12, 59};
  int   mval [3];
  logic mc [3];
  logic mb [3];
  logic me [3];

  // {enable, incremento, decremento, carga}
  localparam logic [3:0] UP     = 4'b1100;
  localparam logic [3:0] DOWN   = 4'b1010;
  localparam logic [3:0] BOTH   = 4'b1110;
  localparam logic [3:0] NOEN   = 4'b0100;
  localparam logic [3:0] LOAD   = 4'b0001;
  localparam logic [3:0] LOADUP = 4'b1101;
  localparam logic [3:0] LOADDN = 4'b1011;

  logic       tick = 1'b0, c_carga = 1'b0;
  logic [3:0] s_msd, s_lsd, m_msd, m_lsd, h_msd, h_lsd;
  logic       s_carry, m_carry, h_carry, s_b, m_b, h_b, s_e, m_e, h_e;

  always #5 clk = ~clk;

  maq_bcd_cont #(.MINIMO(0), .MAXIMO(23)) dut_h24 (
    .maqc_clock(clk), .maqc_reset(rst_n), .maqc_enable(enable),
    .maqc_incremento(inc), .maqc_decremento(dec), .maqc_carga(carga),
    .maqc_carga_msd(cmsd), .maqc_carga_lsd(clsd),
    .maqc_msd(o_msd[0]), .maqc_lsd(o_lsd[0]), .maqc_carry(o_carry[0]),
    .maqc_borrow(o_borrow[0]), .maqc_erro(o_erro[0]));

  maq_bcd_cont #(.MINIMO(1), .MAXIMO(12)) dut_h12 (
    .maqc_clock(clk), .maqc_reset(rst_n), .maqc_enable(enable),
    .maqc_incremento(inc), .maqc_decremento(dec), .maqc_carga(carga),
    .maqc_carga_msd(cmsd), .maqc_carga_lsd(clsd),
    .maqc_msd(o_msd[1]), .maqc_lsd(o_lsd[1]), .maqc_carry(o_carry[1]),
    .maqc_borrow(o_borrow[1]), .maqc_erro(o_erro[1]));

  maq_bcd_cont #(.MINIMO(0), .MAXIMO(59)) dut_m60 (
    .maqc_clock(clk), .maqc_reset(rst_n), .maqc_enable(enable),
    .maqc_incremento(inc), .maqc_decremento(dec), .maqc_carga(carga),
    .maqc_carga_msd(cmsd), .maqc_carga_lsd(clsd),
    .maqc_msd(o_msd[2]), .maqc_lsd(o_lsd[2]), .maqc_carry(o_carry[2]),
    .maqc_borrow(o_borrow[2]), .maqc_erro(o_erro[2]));

  maq_bcd_cont #(.MINIMO(0), .MAXIMO(59)) u_sec (
    .maqc_clock(clk), .maqc_reset(rst_n), .maqc_enable(tick),
    .maqc_incremento(1'b1), .maqc_decremento(1'b0), .maqc_carga(c_carga),
    .maqc_carga_msd(4'd5), .maqc_carga_lsd(4'd9),
    .maqc_msd(s_msd), .maqc_lsd(s_lsd), .maqc_carry(s_carry),
    .maqc_borrow(s_b), .maqc_erro(s_e));

  maq_bcd_cont #(.MINIMO(0), .MAXIMO(59)) u_min (
    .maqc_clock(clk), .maqc_reset(rst_n), .maqc_enable(s_carry),
    .maqc_incremento(1'b1), .maqc_decremento(1'b0), .maqc_carga(c_carga),
    .maqc_carga_msd(4'd5), .maqc_carga_lsd(4'd9),
    .maqc_msd(m_msd), .maqc_lsd(m_lsd), .maqc_carry(m_carry),
    .maqc_borrow(m_b), .maqc_erro(m_e));

  maq_bcd_cont #(.MINIMO(0), .MAXIMO(23)) u_hr (
    .maqc_clock(clk), .maqc_reset(rst_n), .maqc_enable(m_carry),
    .maqc_incremento(1'b1), .maqc_decremento(1'b0), .maqc_carga(c_carga),
    .maqc_carga_msd(4'd2), .maqc_carga_lsd(4'd3),
    .maqc_msd(h_msd), .maqc_lsd(h_lsd), .maqc_carry(h_carry),
    .maqc_borrow(h_b), .maqc_erro(h_e));

  function automatic logic [11:0] st(logic [3:0] op, logic [3:0] m, logic [3:0] u);
    return {op, m, u};
  endfunction

  function automatic logic [10:0] got(int k);
    return {o_msd[k], o_lsd[k], o_carry[k], o_borrow[k], o_erro[k]};
  endfunction

  function automatic logic [10:0] want(int k);
    return {4'(mval[k] / 10), 4'(mval[k] % 10), mc[k], mb[k], me[k]};
  endfunction

  // Reference model: the count is a plain integer in [mn, mx].
  function automatic void model_step();
    for (int k = 0; k < 3; k++) begin
      int lv;
      mc[k] = 1'b0; mb[k] = 1'b0; me[k] = 1'b0;
      lv = 10 * int'(cmsd) + int'(clsd);
      if (carga) begin
        if (cmsd <= 4'd9 && clsd <= 4'd9 && lv >= mn[k] && lv <= mx[k]) mval[k] = lv;
        else me[k] = 1'b1;
      end else if (enable && inc && !dec) begin
        if (mval[k] == mx[k]) begin mval[k] = mn[k]; mc[k] = 1'b1; end
        else mval[k] = mval[k] + 1;
      end else if (enable && dec && !inc) begin
        if (mval[k] == mn[k]) begin mval[k] = mx[k]; mb[k] = 1'b1; end
        else mval[k] = mval[k] - 1;
      end
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      mval[k] = mn[k]; mc[k] = 1'b0; mb[k] = 1'b0; me[k] = 1'b0;
    end
  endfunction

  task automatic apply(input logic [11:0] s);
    {enable, inc, dec, carga, cmsd, clsd} = s;
  endtask

  task automatic tick_cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic assert_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1 model_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got(k) !== want(k)) begin
        errors++; $display("[TB] FAIL reset_init inst%0d: got %h want %h", k, got(k), want(k));
      end
    end
    release_reset();
    apply(st(LOAD, 4'd1, 4'd7));
    tick_cycle();
    apply(st(UP, 4'd0, 4'd0));
    tick_cycle();
    assert_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got(k) !== want(k)) begin
        errors++; $display("[TB] FAIL reset_async inst%0d: got %h want %h", k, got(k), want(k));
      end
    end
    checks++;
    if ({o_msd[0], o_lsd[0]} !== 8'h00) begin
      errors++; $display("[TB] FAIL reset_digits: got %h want 00", {o_msd[0], o_lsd[0]});
    end
    release_reset();
  endtask

  task automatic test_count_wrap();
    apply(st(UP, 4'd0, 4'd0));
    for (int i = 0; i < 24; i++) begin
      tick_cycle();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (got(k) !== want(k)) begin
          errors++; $display("[TB] FAIL count_wrap step%0d inst%0d: got %h want %h", i, k, got(k), want(k));
        end
      end
      checks++;
      if (o_carry[0] !== (i == 23)) begin
        errors++; $display("[TB] FAIL count_wrap_carry step%0d: got %b want %b", i, o_carry[0], (i == 23));
      end
    end
  endtask

  task automatic run_seq(input string name, input logic [11:0] seq [], input int n);
    for (int i = 0; i < n; i++) begin
      apply(seq[i]);
      tick_cycle();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (got(k) !== want(k)) begin
          errors++; $display("[TB] FAIL %s step%0d inst%0d: got %h want %h", name, i, k, got(k), want(k));
        end
      end
    end
  endtask

  task automatic test_h12();
    logic [11:0] seq [];
    assert_reset();
    release_reset();
    seq = new[4];
    seq = '{st(DOWN, 4'd0, 4'd0), st(UP, 4'd0, 4'd0), st(LOAD, 4'd0, 4'd9), st(UP, 4'd0, 4'd0)};
    run_seq("h12", seq, 4);
    checks++;
    if ({o_msd[1], o_lsd[1]} !== 8'h10) begin
      errors++; $display("[TB] FAIL h12_nine_up: got %h want 10", {o_msd[1], o_lsd[1]});
    end
  endtask

  task automatic test_minutes();
    logic [11:0] seq [];
    seq = new[5];
    seq = '{st(LOAD, 4'd5, 4'd9), st(UP, 4'd0, 4'd0), st(DOWN, 4'd0, 4'd0),
            st(LOAD, 4'd4, 4'd0), st(DOWN, 4'd0, 4'd0)};
    run_seq("minutes", seq, 5);
    checks++;
    if ({o_msd[2], o_lsd[2]} !== 8'h39) begin
      errors++; $display("[TB] FAIL minutes_40_down: got %h want 39", {o_msd[2], o_lsd[2]});
    end
  endtask

  task automatic test_invalid_preset();
    logic [11:0] seq [];
    seq = new[4];
    seq = '{st(LOAD, 4'd2, 4'd4), st(LOAD, 4'd1, 4'd10), st(LOAD, 4'd0, 4'd0), st(LOAD, 4'd2, 4'd3)};
    run_seq("preset", seq, 4);
  endtask

  task automatic test_conflicts();
    logic [11:0] seq [];
    seq = new[5];
    seq = '{st(BOTH, 4'd0, 4'd0), st(NOEN, 4'd0, 4'd0), st(LOADUP, 4'd1, 4'd1),
            st(LOADDN, 4'd0, 4'd5), st(BOTH, 4'd0, 4'd0)};
    run_seq("conflict", seq, 5);
  endtask

  task automatic test_reset_mid_pulse();
    apply(st(LOAD, 4'd2, 4'd3));
    tick_cycle();
    apply(st(UP, 4'd0, 4'd0));
    tick_cycle();
    checks++;
    if (o_carry[0] !== 1'b1) begin
      errors++; $display("[TB] FAIL pulse_before_reset: got %b want 1", o_carry[0]);
    end
    assert_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got(k) !== want(k)) begin
        errors++; $display("[TB] FAIL reset_mid_pulse inst%0d: got %h want %h", k, got(k), want(k));
      end
    end
    release_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      apply(st({1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0)},
               4'($urandom_range(0, 7)), 4'($urandom_range(0, 11))));
      tick_cycle();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (got(k) !== want(k)) begin
          errors++; $display("[TB] FAIL random step%0d inst%0d: got %h want %h", i, k, got(k), want(k));
        end
      end
    end
  endtask

  task automatic test_cascade();
    logic [27:0] exp_seq [6];
    int hr_carries;
    // {sec, min, hour digits, sec carry, min carry, hour carry, any borrow/erro}
    exp_seq = '{{8'h59, 8'h59, 8'h23, 4'b0000}, {8'h00, 8'h59, 8'h23, 4'b1000},
                {8'h00, 8'h00, 8'h23, 4'b0100}, {8'h00, 8'h00, 8'h00, 4'b0010},
                {8'h00, 8'h00, 8'h00, 4'b0000}, {8'h00, 8'h00, 8'h00, 4'b0000}};
    hr_carries = 0;
    apply(st(4'b0000, 4'd0, 4'd0));
    c_carga = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      c_carga = 1'b0;
      tick = (i == 0);
      if (h_carry) hr_carries++;
      checks++;
      if ({s_msd, s_lsd, m_msd, m_lsd, h_msd, h_lsd, s_carry, m_carry, h_carry,
           s_b | m_b | h_b | s_e | m_e | h_e} !== exp_seq[i]) begin
        errors++;
        $display("[TB] FAIL cascade cycle%0d: got %h want %h", i,
                 {s_msd, s_lsd, m_msd, m_lsd, h_msd, h_lsd, s_carry, m_carry, h_carry,
                  s_b | m_b | h_b | s_e | m_e | h_e}, exp_seq[i]);
      end
    end
    tick = 1'b0;
    checks++;
    if (hr_carries != 1) begin
      errors++; $display("[TB] FAIL cascade_hour_carries: got %0d want 1", hr_carries);
    end
  endtask

  initial begin
    test_reset();
    test_count_wrap();
    test_h12();
    test_minutes();
    test_invalid_preset();
    test_conflicts();
    test_reset_mid_pulse();
    test_random();
    test_cascade();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/maq_bcd_cont.md
# maq_bcd_cont

Parametrised two-digit BCD modulo counter that generalises the clock's hour/minute/second digit machines into one block. It counts up or down between configurable bounds (MINIMO..MAXIMO), supports synchronous preset for time setting, and emits single-cycle carry/borrow pulses so instances cascade (seconds → minutes → hours). It sits in the clock datapath between the 1 Hz tick generator and the 7-segment decoders; one instance per time field.

## Interface
Parameters:
- MINIMO, default 0, lowest count value (decimal, 0..98); 1 gives a 12 h hour field (01..12)
- MAXIMO, default 23, highest count value (decimal, MINIMO+1..99); 59 for minutes/seconds, 12 for 12 h hours
- Illegal combination (MINIMO >= MAXIMO, MAXIMO > 99) must stop elaboration with an error

Ports:
- maqc_clock  in  1  single clock, all state on rising edge
- maqc_reset  in  1  asynchronous, active-low reset
- maqc_enable  in  1  tick qualifier; counting happens only when high
- maqc_incremento  in  1  count-up request
- maqc_decremento  in  1  count-down request
- maqc_carga  in  1  synchronous preset strobe, independent of maqc_enable
- maqc_carga_msd  in  4  preset tens digit (BCD)
- maqc_carga_lsd  in  4  preset units digit (BCD)
- maqc_msd  out  4  tens digit (BCD)
- maqc_lsd  out  4  units digit (BCD)
- maqc_carry  out  1  one-cycle pulse: up-count wrapped MAXIMO→MINIMO
- maqc_borrow  out  1  one-cycle pulse: down-count wrapped MINIMO→MAXIMO
- maqc_erro  out  1  one-cycle pulse: preset rejected

## Operation
- Reset (maqc_reset low, any time, no clock needed): msd/lsd = BCD of MINIMO; carry, borrow, erro = 0. Held while low.
- Per rising edge, priority: preset > up > down > hold.
- Preset (maqc_carga=1): valid iff both digits <= 9 and 10*msd+lsd within [MINIMO, MAXIMO]. Valid → digits take preset value, erro=0. Invalid → digits hold, erro=1. No carry/borrow on preset, even if value equals a bound.
- Up (carga=0, enable=1, incremento=1, decremento=0):
  - value == MAXIMO → MINIMO, carry=1
  - else lsd == 9 → lsd=0, msd+1
  - else lsd+1
- Down (carga=0, enable=1, decremento=1, incremento=0):
  - value == MINIMO → MAXIMO, borrow=1
  - else lsd == 0 → lsd=9, msd−1
  - else lsd−1
- incremento and decremento both high, or enable low → hold, no pulses.
- carry/borrow/erro are registered and cleared on every edge where their condition is absent; never high together.
- Digits never leave [MINIMO, MAXIMO] or hold a non-BCD code; comparisons use the full two-digit value, not lsd alone (e.g. 19→20 in a 0..23 counter, 23→00).

## Timing
- Latency 1 cycle: new digits and any pulse visible after the same rising edge that samples the request; pulse aligned with the wrapped value.
- Pulses last exactly one cycle per qualifying edge; enable held high for N cycles with incremento high gives N steps.
- Cascading: maqc_carry of one instance drives maqc_enable of the next (incremento tied high); next field steps one cycle after the wrap.
- Reset deassertion mid-operation: first edge after release evaluates normally from MINIMO.
- Reset assertion mid-pulse: pulse drops immediately (asynchronous).

## Test plan
- Reset/default bounds (0..23): assert reset low during count at 17 → outputs 0/0, flags 0 immediately; release, 24 up-steps → 01,02..23,00 with carry high only on the 23→00 cycle.
- 12 h bounds (MINIMO=1, MAXIMO=12): reset → 01; down-step → 12 with borrow=1; up-step → 01 with carry=1; 09 up → 10.
- Minutes (0..59): preset 5/9 → 59; up → 00, carry=1; down → 59, borrow=1; 40 down → 39.
- Invalid presets (0..23): load 2/4 (24), 1/10 (non-BCD), and 0/0 with MINIMO=1 → value unchanged, erro=1 for one cycle each; valid 2/3 → 23, erro=0, no carry.
- Conflicts: incremento=decremento=1 with enable → hold; enable=0 with incremento → hold; carga with incremento → preset wins, no step, no carry.
- Cascade: seconds→minutes→hours at 23:59:59, one tick → 00:00:00, with minute and hour wraps on successive cycles and a single carry from hours.
